// File: rtl/rrobin_watchdog.sv
// rtl/rrobin_watchdog.sv - runtime fairness/safety checker for a two-client round-robin arbiter
module rrobin_watchdog #(
    parameter int WAIT_W   = 4,
    parameter int MAX_WAIT = 3,
    parameter int GCNT_W   = 8
) (
    input  logic              clock,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              req1,
    input  logic              ack0,
    input  logic              ack1,
    output logic              starve0,
    output logic              starve1,
    output logic              mutex_err,
    output logic              spur_err,
    output logic [GCNT_W-1:0] grant_cnt0,
    output logic [GCNT_W-1:0] grant_cnt1,
    output logic              round_done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PEND  = 2'd1,
        GRANT = 2'd2
    } ch_state_t;

    // Threshold and saturation value held at counter width so the compare is unsigned.
    localparam logic [WAIT_W-1:0] MAX_WAIT_W = WAIT_W'(MAX_WAIT);
    localparam logic [WAIT_W-1:0] WAIT_SAT   = {WAIT_W{1'b1}};
    localparam logic [GCNT_W-1:0] GCNT_SAT   = {GCNT_W{1'b1}};

    logic [1:0]        req;
    logic [1:0]        ack;
    ch_state_t         state_q [2];
    ch_state_t         state_d [2];
    logic [WAIT_W-1:0] wait_q  [2];
    logic [WAIT_W-1:0] wait_d  [2];
    logic [1:0]        starve_d;
    logic [1:0]        prev_req_q;
    logic [1:0]        served_q;
    logic [1:0]        served_nxt;
    logic              round_hit;

    assign req = {req1, req0};
    assign ack = {ack1, ack0};

    // Per-client channel FSM and wait counter; both channels step independently.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            state_d[i] = state_q[i];
            wait_d[i]  = '0;
            case (state_q[i])
                IDLE: begin
                    if (ack[i]) begin
                        state_d[i] = GRANT;
                    end else if (req[i]) begin
                        state_d[i] = PEND;
                        wait_d[i]  = WAIT_W'(1);
                    end
                end
                PEND: begin
                    if (ack[i]) begin
                        state_d[i] = GRANT;
                    end else if (!req[i]) begin
                        state_d[i] = IDLE;
                    end else begin
                        wait_d[i] = (wait_q[i] == WAIT_SAT) ? wait_q[i] : wait_q[i] + WAIT_W'(1);
                    end
                end
                GRANT: begin
                    if (ack[i]) begin
                        state_d[i] = req[i] ? GRANT : IDLE;
                    end else if (req[i]) begin
                        state_d[i] = PEND;
                        wait_d[i]  = WAIT_W'(1);
                    end else begin
                        state_d[i] = IDLE;
                    end
                end
                default: begin
                    state_d[i] = IDLE;
                end
            endcase
            starve_d[i] = (wait_d[i] >= MAX_WAIT_W);
        end
    end

    // Round tracking: a round closes once both clients have seen an ack.
    always_comb begin
        served_nxt = served_q | ack;
        round_hit  = &served_nxt;
    end

    // Channel state, wait counters and starvation flags.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                state_q[i] <= IDLE;
                wait_q[i]  <= '0;
            end
            starve0 <= 1'b0;
            starve1 <= 1'b0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                state_q[i] <= state_d[i];
                wait_q[i]  <= wait_d[i];
            end
            starve0 <= starve_d[0];
            starve1 <= starve_d[1];
        end
    end

    // Sticky protocol errors, saturating grant counters and round pulse.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            prev_req_q <= 2'b00;
            served_q   <= 2'b00;
            mutex_err  <= 1'b0;
            spur_err   <= 1'b0;
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
            round_done <= 1'b0;
        end else begin
            prev_req_q <= req;
            if (ack0 && ack1) begin
                mutex_err <= 1'b1;
            end
            if (|(ack & ~prev_req_q)) begin
                spur_err <= 1'b1;
            end
            if (ack0 && (grant_cnt0 != GCNT_SAT)) begin
                grant_cnt0 <= grant_cnt0 + GCNT_W'(1);
            end
            if (ack1 && (grant_cnt1 != GCNT_SAT)) begin
                grant_cnt1 <= grant_cnt1 + GCNT_W'(1);
            end
            round_done <= round_hit;
            served_q   <= round_hit ? 2'b00 : served_nxt;
        end
    end

endmodule

// File: tb/tb_rrobin_watchdog.sv
// tb/tb_rrobin_watchdog.sv - scoreboard bench for rrobin_watchdog with directed vectors
module tb_rrobin_watchdog;

    typedef struct packed {
        logic       s0;
        logic       s1;
        logic       mx;
        logic       sp;
        logic       rd;
        logic [7:0] gc0;
        logic [7:0] gc1;
        logic [1:0] h0;
        logic [1:0] h1;
    } exp_t;

    logic       clock = 1'b0;
    logic       rst_n = 1'b0;
    logic       req0  = 1'b0;
    logic       req1  = 1'b0;
    logic       ack0  = 1'b0;
    logic       ack1  = 1'b0;
    logic       starve0, starve1, mutex_err, spur_err, round_done;
    logic [7:0] grant_cnt0, grant_cnt1;
    logic       b_starve0, b_starve1, b_mutex_err, b_spur_err, b_round_done;
    logic [1:0] b_grant_cnt0, b_grant_cnt1;

    exp_t  exp_q[$];
    string tag_q[$];
    int    n_cmp  = 0;
    int    n_fail = 0;

    rrobin_watchdog #(.WAIT_W(4), .MAX_WAIT(3), .GCNT_W(8)) dut (
        .clock(clock), .rst_n(rst_n),
        .req0(req0), .req1(req1), .ack0(ack0), .ack1(ack1),
        .starve0(starve0), .starve1(starve1),
        .mutex_err(mutex_err), .spur_err(spur_err),
        .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1),
        .round_done(round_done)
    );

    rrobin_watchdog #(.WAIT_W(4), .MAX_WAIT(3), .GCNT_W(2)) dut_narrow (
        .clock(clock), .rst_n(rst_n),
        .req0(req0), .req1(req1), .ack0(ack0), .ack1(ack1),
        .starve0(b_starve0), .starve1(b_starve1),
        .mutex_err(b_mutex_err), .spur_err(b_spur_err),
        .grant_cnt0(b_grant_cnt0), .grant_cnt1(b_grant_cnt1),
        .round_done(b_round_done)
    );

    always #5 clock = ~clock;

    function automatic exp_t mk(input bit s0, input bit s1, input bit mx, input bit sp,
                                input bit rd, input int g0, input int g1,
                                input int h0, input int h1);
        exp_t e;
        e.s0  = s0;
        e.s1  = s1;
        e.mx  = mx;
        e.sp  = sp;
        e.rd  = rd;
        e.gc0 = 8'(g0);
        e.gc1 = 8'(g1);
        e.h0  = 2'(h0);
        e.h1  = 2'(h1);
        return e;
    endfunction

    localparam exp_t Z = '0;

    task automatic step(input bit rst, input bit r0, input bit r1, input bit a0, input bit a1,
                        input exp_t e, input string tag);
        @(negedge clock);
        rst_n = rst;
        req0  = r0;
        req1  = r1;
        ack0  = a0;
        ack1  = a1;
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    // Monitor: outputs settle after each clock edge or asynchronous reset.
    initial begin
        exp_t  e;
        exp_t  act;
        string t;
        forever begin
            @(posedge clock or negedge rst_n);
            #1;
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                t   = tag_q.pop_front();
                act = mk(starve0, starve1, mutex_err, spur_err, round_done,
                         int'(grant_cnt0), int'(grant_cnt1),
                         int'(b_grant_cnt0), int'(b_grant_cnt1));
                n_cmp++;
                if (act !== e) begin
                    n_fail++;
                    $display("FAIL %s: got s0=%b s1=%b mx=%b sp=%b rd=%b gc0=%0d gc1=%0d n0=%0d n1=%0d want s0=%b s1=%b mx=%b sp=%b rd=%b gc0=%0d gc1=%0d n0=%0d n1=%0d",
                             t, act.s0, act.s1, act.mx, act.sp, act.rd, act.gc0, act.gc1, act.h0, act.h1,
                             e.s0, e.s1, e.mx, e.sp, e.rd, e.gc0, e.gc1, e.h0, e.h1);
                end
            end
        end
    end

    initial begin
        int k;
        // Reset state
        step(0, 0,0,0,0, Z, "reset_a");
        step(0, 0,0,0,0, Z, "reset_b");

        // T1: req0 only, ack0 one cycle later held 5 cycles (narrow copy saturates at 3)
        step(1, 1,0,0,0, Z,                              "t1_pend");
        step(1, 1,0,1,0, mk(0,0,0,0,0, 1,0, 1,0),       "t1_ack1");
        step(1, 1,0,1,0, mk(0,0,0,0,0, 2,0, 2,0),       "t1_ack2");
        step(1, 1,0,1,0, mk(0,0,0,0,0, 3,0, 3,0),       "t1_ack3");
        step(1, 1,0,1,0, mk(0,0,0,0,0, 4,0, 3,0),       "t1_ack4_sat");
        step(1, 1,0,1,0, mk(0,0,0,0,0, 5,0, 3,0),       "t1_ack5_sat");
        step(1, 0,0,0,0, mk(0,0,0,0,0, 5,0, 3,0),       "t1_idle");
        step(0, 0,0,0,0, Z,                              "t1_rst");

        // T2: both requesting, acks alternate
        step(1, 1,1,0,0, Z,                              "t2_pend");
        step(1, 1,1,1,0, mk(0,0,0,0,0, 1,0, 1,0),       "t2_a0");
        step(1, 1,1,0,1, mk(0,0,0,0,1, 1,1, 1,1),       "t2_a1_round");
        step(1, 1,1,1,0, mk(0,0,0,0,0, 2,1, 2,1),       "t2_a0b");
        step(1, 1,1,0,1, mk(0,0,0,0,1, 2,2, 2,2),       "t2_a1b_round");
        step(1, 0,0,0,0, mk(0,0,0,0,0, 2,2, 2,2),       "t2_idle");
        step(0, 0,0,0,0, Z,                              "t2_rst");

        // T3: client 1 starves, then is acked
        step(1, 0,1,0,0, Z,                              "t3_wait1");
        step(1, 0,1,0,0, Z,                              "t3_wait2");
        step(1, 0,1,0,0, mk(0,1,0,0,0, 0,0, 0,0),       "t3_wait3_starve");
        step(1, 0,1,0,0, mk(0,1,0,0,0, 0,0, 0,0),       "t3_wait4_starve");
        step(1, 0,1,0,1, mk(0,0,0,0,0, 0,1, 0,1),       "t3_ack_clear");
        step(1, 0,0,0,0, mk(0,0,0,0,0, 0,1, 0,1),       "t3_idle");
        step(0, 0,0,0,0, Z,                              "t3_rst");

        // T4: simultaneous acks -> mutex error, one round pulse, sticky until reset
        step(1, 1,1,0,0, Z,                              "t4_pend");
        step(1, 1,1,1,1, mk(0,0,1,0,1, 1,1, 1,1),       "t4_both");
        step(1, 0,0,0,0, mk(0,0,1,0,0, 1,1, 1,1),       "t4_sticky1");
        step(1, 0,0,0,0, mk(0,0,1,0,0, 1,1, 1,1),       "t4_sticky2");
        step(0, 0,0,0,0, Z,                              "t4_rst_clear");

        // T5: ack1 without prior req1
        step(1, 0,0,0,0, Z,                              "t5_quiet");
        step(1, 0,0,0,1, mk(0,0,0,1,0, 0,1, 0,1),       "t5_spur");
        step(1, 0,0,0,0, mk(0,0,0,1,0, 0,1, 0,1),       "t5_sticky");
        step(0, 0,0,0,0, Z,                              "t5_rst");

        // Ack in the first cycle after reset is spurious
        step(1, 1,0,1,0, mk(0,0,0,1,0, 1,0, 1,0),       "first_ack_spur");
        step(0, 0,0,0,0, Z,                              "first_rst");

        // T6: asynchronous reset while client 1 is pending and starving
        step(1, 0,1,0,0, Z,                              "t6_wait1");
        step(1, 0,1,0,0, Z,                              "t6_wait2");
        step(1, 0,1,0,0, mk(0,1,0,0,0, 0,0, 0,0),       "t6_starve");
        @(negedge clock);
        #2;
        exp_q.push_back(Z);
        tag_q.push_back("t6_async_rst");
        rst_n = 1'b0;
        step(0, 0,1,0,0, Z,                              "t6_held");
        step(1, 0,0,0,0, Z,                              "t6_release");

        k = 0;
        while (exp_q.size() > 0 && k < 10) begin
            @(posedge clock);
            k++;
        end
        #2;
        if (exp_q.size() > 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain: got %0d pending entries want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
